mem_access: RTL and testbench

- Memory stage directly downstream of the execute stage; owns the EX/MEM pipeline register.
- Consumes the execute stage's ALU result, Rt store data, destination register address and memory/writeback controls.
- Runs a req/ack data-bus transaction for loads and stores: byte-lane steering, alignment checking, load extension, bus timeout.
- Produces a single writeback value for WB and a Stall to freeze upstream stages while a transaction is outstanding.

---
 rtl/mem_access.sv | 186 ++++++++++++++++++
 tb/tb_mem_access.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory stage: owns the EX/MEM register and runs one req/ack data-bus transaction
// per load/store, with lane steering, alignment check, load extension and bus timeout.

module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        RegWriteIn,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic        MemtoRegIn,
    input  logic [31:0] ALUOutIn,
    input  logic [31:0] RtDataIn,
    input  logic [4:0]  RAddrIn,
    input  logic [1:0]  Size,
    input  logic        SignedLoad,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DByteEn,
    output logic        DRead,
    output logic        DWrite,
    input  logic        DAck,
    input  logic [31:0] DRData,
    output logic [31:0] WBData,
    output logic [4:0]  RAddrOut,
    output logic        RegWriteOut,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr
);

    // state  | meaning
    // IDLE   | accepting a new instruction from execute every cycle
    // ACCESS | bus request outstanding, upstream frozen via Stall

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;

    logic            mem_op, misaligned;
    logic            accept, addr_fault, done, expire;
    logic [3:0]      be_in;
    logic [31:0]     wdata_in;
    logic [31:0]     load_ext, lane_sh;
    logic [15:0]     half_sel;

    logic [31:0]     alu_q;
    logic [1:0]      size_q;
    logic            sgn_q, m2r_q, rw_q, st_q;

    assign mem_op = MemReadIn | MemWriteIn;

    always_comb begin
        misaligned = 1'b0;
        be_in      = 4'b1111;
        wdata_in   = RtDataIn;
        unique case (Size)
            2'b00: begin
                misaligned = 1'b0;
                be_in      = 4'b0001 << ALUOutIn[1:0];
                wdata_in   = {4{RtDataIn[7:0]}};
            end
            2'b01: begin
                misaligned = ALUOutIn[0];
                be_in      = ALUOutIn[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{RtDataIn[15:0]}};
            end
            default: begin
                misaligned = |ALUOutIn[1:0];
                be_in      = 4'b1111;
                wdata_in   = RtDataIn;
            end
        endcase
    end

    // Lane selection uses the address latched at accept time, not the live input.
    always_comb begin
        lane_sh  = DRData >> {alu_q[1:0], 3'b000};
        half_sel = alu_q[1] ? DRData[31:16] : DRData[15:0];
        load_ext = DRData;
        unique case (size_q)
            2'b00:   load_ext = {{24{sgn_q & lane_sh[7]}}, lane_sh[7:0]};
            2'b01:   load_ext = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: load_ext = DRData;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = ACCESS;
            ACCESS:  if (done || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DAck on the terminal cycle counts as completion, so expire excludes it.
    always_comb begin
        Stall      = (state == ACCESS);
        accept     = (state == IDLE) && mem_op && !misaligned;
        addr_fault = (state == IDLE) && mem_op && misaligned;
        done       = (state == ACCESS) && DAck;
        expire     = (state == ACCESS) && !DAck && (cnt == CNT_LAST);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt <= '0;
        end else if ((state == ACCESS) && !done && !expire) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            DAddr       <= '0;
            DWData      <= '0;
            DByteEn     <= '0;
            DRead       <= 1'b0;
            DWrite      <= 1'b0;
            WBData      <= '0;
            RAddrOut    <= '0;
            RegWriteOut <= 1'b0;
            AddrErr     <= 1'b0;
            BusErr      <= 1'b0;
            alu_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            m2r_q       <= 1'b0;
            rw_q        <= 1'b0;
            st_q        <= 1'b0;
        end else begin
            AddrErr <= addr_fault;
            BusErr  <= expire;
            if (state == IDLE) begin
                if (!mem_op) begin
                    WBData      <= ALUOutIn;
                    RAddrOut    <= RAddrIn;
                    RegWriteOut <= RegWriteIn;
                end else if (misaligned) begin
                    RegWriteOut <= 1'b0;
                end else begin
                    RegWriteOut <= 1'b0;
                    RAddrOut    <= RAddrIn;
                    alu_q       <= ALUOutIn;
                    size_q      <= Size;
                    sgn_q       <= SignedLoad;
                    m2r_q       <= MemtoRegIn;
                    rw_q        <= RegWriteIn;
                    st_q        <= MemWriteIn;
                    DAddr       <= {ALUOutIn[31:2], 2'b00};
                    DWData      <= wdata_in;
                    DByteEn     <= be_in;
                    DRead       <= ~MemWriteIn;
                    DWrite      <= MemWriteIn;
                end
            end else if (done) begin
                DRead  <= 1'b0;
                DWrite <= 1'b0;
                if (st_q) begin
                    RegWriteOut <= 1'b0;
                end else begin
                    RegWriteOut <= rw_q;
                    WBData      <= m2r_q ? load_ext : alu_q;
                end
            end else if (expire) begin
                DRead       <= 1'b0;
                DWrite      <= 1'b0;
                RegWriteOut <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: random loads/stores against a byte-lane reference model,
// plus directed alignment, timeout and mid-transaction reset scenarios.

module tb_mem_access;

    localparam int TO = 16;

    logic        Clock, nReset;
    logic        RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn, SignedLoad;
    logic [31:0] ALUOutIn, RtDataIn, DRData;
    logic [4:0]  RAddrIn;
    logic [1:0]  Size;
    logic [31:0] DAddr, DWData, WBData;
    logic [3:0]  DByteEn;
    logic        DRead, DWrite, DAck;
    logic [4:0]  RAddrOut;
    logic        RegWriteOut, Stall, AddrErr, BusErr;

    int tests = 0;
    int fails = 0;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock(Clock), .nReset(nReset),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemtoRegIn(MemtoRegIn), .ALUOutIn(ALUOutIn), .RtDataIn(RtDataIn),
        .RAddrIn(RAddrIn), .Size(Size), .SignedLoad(SignedLoad),
        .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn),
        .DRead(DRead), .DWrite(DWrite), .DAck(DAck), .DRData(DRData),
        .WBData(WBData), .RAddrOut(RAddrOut), .RegWriteOut(RegWriteOut),
        .Stall(Stall), .AddrErr(AddrErr), .BusErr(BusErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Reference model: pick the addressed bytes arithmetically and sign-extend by subtraction.
    function automatic logic [31:0] ref_load(logic [31:0] rd, logic [1:0] sz, logic [1:0] a, logic sgn);
        int     nb, sh;
        longint v;
        nb = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        sh = (sz == 2'd0) ? 8 * int'(a) : (sz == 2'd1) ? 16 * int'(a[1]) : 0;
        v  = longint'(rd >> sh) & ((longint'(1) << nb) - 1);
        if (sgn && nb < 32 && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] rt, logic [1:0] sz);
        if (sz == 2'd0) return 32'(rt[7:0]) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(rt[15:0]) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] sz, logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic set_nop(input logic [31:0] alu, input logic [4:0] ra, input logic rw);
        MemReadIn  = 1'b0;
        MemWriteIn = 1'b0;
        MemtoRegIn = 1'($urandom);
        RegWriteIn = rw;
        ALUOutIn   = alu;
        RAddrIn    = ra;
        RtDataIn   = $urandom;
        Size       = 2'($urandom);
        SignedLoad = 1'($urandom);
    endtask

    // Issues one memory op, acks on stall cycle ack_at (0 = never), holds a non-memory
    // op upstream during the stall, and returns at the negedge after Stall drops.
    task automatic mem_txn(
        input  logic rd, input logic wr, input logic [1:0] sz,
        input  logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rdata,
        input  logic sgn, input logic m2r, input logic rw, input logic [4:0] ra,
        input  int ack_at, input logic [31:0] hold_alu, input logic [4:0] hold_ra,
        output int ncyc, output logic [31:0] daddr_o, output logic [31:0] wdata_o,
        output logic [3:0] be_o, output logic rd_o, output logic wr_o,
        output logic stable_o, output logic rw_during);
        @(negedge Clock);
        MemReadIn = rd; MemWriteIn = wr; Size = sz; ALUOutIn = addr; RtDataIn = rt;
        SignedLoad = sgn; MemtoRegIn = m2r; RegWriteIn = rw; RAddrIn = ra; DAck = 1'b0;
        @(posedge Clock);
        ncyc = 0; stable_o = 1'b1; rw_during = 1'b0; rd_o = 1'b0; wr_o = 1'b0;
        daddr_o = '0; wdata_o = '0; be_o = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            rd_o = rd_o | DRead;
            wr_o = wr_o | DWrite;
            if (!Stall) break;
            ncyc++;
            if (ncyc == 1) begin
                daddr_o = DAddr; wdata_o = DWData; be_o = DByteEn;
            end else if (DAddr !== daddr_o || DWData !== wdata_o || DByteEn !== be_o) begin
                stable_o = 1'b0;
            end
            rw_during = rw_during | RegWriteOut;
            set_nop(hold_alu, hold_ra, 1'b1);
            DAck   = (ncyc == ack_at);
            DRData = DAck ? rdata : $urandom;
            @(posedge Clock);
        end
        DAck = 1'b0;
        set_nop(hold_alu, hold_ra, 1'b1);
    endtask

    task automatic test_reset();
        nReset = 1'b0; DAck = 1'b0; DRData = '0;
        set_nop(32'h1234_5678, 5'd3, 1'b1);
        #2;
        tests++; if ({DAddr, DWData, DByteEn, DRead, DWrite, WBData, RAddrOut, RegWriteOut, Stall, AddrErr, BusErr} !== '0) begin
            fails++; $display("FAIL reset_outputs: WBData=%h DRead=%b Stall=%b RegWriteOut=%b, required all zero", WBData, DRead, Stall, RegWriteOut); end
        repeat (2) @(posedge Clock);
        #1;
        tests++; if (WBData !== 32'h0 || RegWriteOut !== 1'b0) begin
            fails++; $display("FAIL reset_hold: WBData=%h RegWriteOut=%b, required 0/0", WBData, RegWriteOut); end
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic test_alu_pass();
        logic [31:0] alu;
        logic [4:0]  ra;
        logic        rw;
        @(negedge Clock);
        for (int i = 0; i < 12; i++) begin
            alu = (i == 0) ? 32'h1234_5678 : $urandom;
            ra  = (i == 0) ? 5'd5 : 5'($urandom);
            rw  = (i == 0) ? 1'b1 : 1'($urandom);
            set_nop(alu, ra, rw);
            DAck = 1'($urandom);
            DRData = $urandom;
            @(negedge Clock);
            tests++; if (WBData !== alu || RAddrOut !== ra || RegWriteOut !== rw || Stall !== 1'b0) begin
                fails++; $display("FAIL alu_pass[%0d]: WBData=%h RAddrOut=%0d RegWriteOut=%b Stall=%b, required %h %0d %b 0", i, WBData, RAddrOut, RegWriteOut, Stall, alu, ra, rw); end
        end
        DAck = 1'b0;
    endtask

    task automatic test_load_directed();
        int n; logic [31:0] da, wd; logic [3:0] be; logic r, w, st, rwd;
        logic [31:0] exp_wb;
        for (int s = 0; s < 2; s++) begin
            exp_wb = (s == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            mem_txn(1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, (s == 0), 1'b1, 1'b1, 5'd7,
                    4, 32'h0, 5'd0, n, da, wd, be, r, w, st, rwd);
            tests++; if (n !== 4) begin fails++; $display("FAIL lb_stall_cycles[%0d]: got %0d required 4", s, n); end
            tests++; if (da !== 32'h100 || be !== 4'b1000 || r !== 1'b1 || w !== 1'b0 || st !== 1'b1) begin
                fails++; $display("FAIL lb_bus[%0d]: DAddr=%h DByteEn=%b DRead=%b DWrite=%b stable=%b, required 100 1000 1 0 1", s, da, be, r, w, st); end
            tests++; if (WBData !== exp_wb || RegWriteOut !== 1'b1 || RAddrOut !== 5'd7 || rwd !== 1'b0) begin
                fails++; $display("FAIL lb_result[%0d]: WBData=%h RegWriteOut=%b RAddrOut=%0d, required %h 1 7", s, WBData, RegWriteOut, RAddrOut, exp_wb); end
        end
    endtask

    task automatic test_random_loads();
        int n, ack; logic [31:0] da, wd; logic [3:0] be; logic r, w, st, rwd;
        logic [1:0] sz; logic [31:0] addr, rdata, exp_wb; logic sgn, m2r, rw; logic [4:0] ra;
        for (int i = 0; i < 16; i++) begin
            sz = 2'($urandom); addr = $urandom; rdata = $urandom;
            if (sz == 2'd1) addr[0] = 1'b0;
            if (sz >= 2'd2) addr[1:0] = 2'b00;
            sgn = 1'($urandom); m2r = 1'($urandom); rw = 1'($urandom); ra = 5'($urandom);
            ack = int'($urandom_range(1, 5));
            exp_wb = m2r ? ref_load(rdata, sz, addr[1:0], sgn) : addr;
            mem_txn(1'b1, 1'b0, sz, addr, $urandom, rdata, sgn, m2r, rw, ra,
                    ack, 32'h0, 5'd0, n, da, wd, be, r, w, st, rwd);
            tests++; if (n !== ack || da !== {addr[31:2], 2'b00} || be !== ref_be(sz, addr[1:0]) || r !== 1'b1 || w !== 1'b0 || st !== 1'b1) begin
                fails++; $display("FAIL load_bus[%0d]: cycles=%0d DAddr=%h DByteEn=%b rd=%b wr=%b stable=%b, required %0d %h %b 1 0 1", i, n, da, be, r, w, st, ack, {addr[31:2], 2'b00}, ref_be(sz, addr[1:0])); end
            tests++; if (WBData !== exp_wb || RegWriteOut !== rw || RAddrOut !== ra || rwd !== 1'b0) begin
                fails++; $display("FAIL load_wb[%0d]: WBData=%h RegWriteOut=%b RAddrOut=%0d, required %h %b %0d (size %0d addr %h data %h)", i, WBData, RegWriteOut, RAddrOut, exp_wb, rw, ra, sz, addr, rdata); end
        end
    endtask

    task automatic test_stores();
        int n, ack; logic [31:0] da, wd; logic [3:0] be; logic r, w, st, rwd;
        logic [1:0] sz; logic [31:0] addr, rt;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                sz = 2'b01; addr = 32'h0000_0202; rt = 32'hAAAA_BEEF; ack = 2;
            end else begin
                sz = 2'($urandom); addr = $urandom; rt = $urandom; ack = int'($urandom_range(1, 4));
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz >= 2'd2) addr[1:0] = 2'b00;
            end
            mem_txn(1'($urandom), 1'b1, sz, addr, rt, $urandom, 1'($urandom), 1'($urandom), 1'b1, 5'($urandom),
                    ack, 32'h0, 5'd0, n, da, wd, be, r, w, st, rwd);
            tests++; if (wd !== ref_wdata(rt, sz) || be !== ref_be(sz, addr[1:0]) || da !== {addr[31:2], 2'b00} || w !== 1'b1 || r !== 1'b0 || st !== 1'b1 || n !== ack) begin
                fails++; $display("FAIL store_bus[%0d]: DWData=%h DByteEn=%b DAddr=%h wr=%b rd=%b stable=%b cycles=%0d, required %h %b %h 1 0 1 %0d", i, wd, be, da, w, r, st, n, ref_wdata(rt, sz), ref_be(sz, addr[1:0]), {addr[31:2], 2'b00}, ack); end
            tests++; if (RegWriteOut !== 1'b0 || rwd !== 1'b0) begin
                fails++; $display("FAIL store_regwrite[%0d]: RegWriteOut=%b during=%b, required 0 0", i, RegWriteOut, rwd); end
        end
    endtask

    task automatic test_misaligned();
        int n; logic [31:0] da, wd; logic [3:0] be; logic r, w, st, rwd;
        logic [1:0] sz; logic [31:0] addr;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                sz = 2'b10; addr = 32'h0000_0101;
            end else begin
                sz = 2'($urandom_range(1, 3)); addr = $urandom;
                if (sz == 2'd1) addr[0] = 1'b1;
                else if (addr[1:0] == 2'b00) addr[0] = 1'b1;
            end
            mem_txn(1'b1, 1'($urandom), sz, addr, $urandom, $urandom, 1'b0, 1'b1, 1'b1, 5'd4,
                    1, 32'h0, 5'd0, n, da, wd, be, r, w, st, rwd);
            tests++; if (n !== 0 || AddrErr !== 1'b1 || RegWriteOut !== 1'b0 || r !== 1'b0 || w !== 1'b0) begin
                fails++; $display("FAIL misaligned[%0d]: stall_cycles=%0d AddrErr=%b RegWriteOut=%b rd=%b wr=%b, required 0 1 0 0 0", i, n, AddrErr, RegWriteOut, r, w); end
            @(negedge Clock);
            tests++; if (AddrErr !== 1'b0) begin
                fails++; $display("FAIL misaligned_pulse[%0d]: AddrErr=%b one cycle later, required 0", i, AddrErr); end
        end
    endtask

    task automatic test_timeout();
        int n; logic [31:0] da, wd; logic [3:0] be; logic r, w, st, rwd;
        mem_txn(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd2,
                0, 32'h0, 5'd0, n, da, wd, be, r, w, st, rwd);
        tests++; if (n !== TO || BusErr !== 1'b1 || RegWriteOut !== 1'b0 || DRead !== 1'b0) begin
            fails++; $display("FAIL timeout: cycles=%0d BusErr=%b RegWriteOut=%b DRead=%b, required %0d 1 0 0", n, BusErr, RegWriteOut, DRead, TO); end
        @(negedge Clock);
        tests++; if (BusErr !== 1'b0) begin
            fails++; $display("FAIL timeout_pulse: BusErr=%b one cycle later, required 0", BusErr); end
        mem_txn(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd2,
                TO, 32'h0, 5'd0, n, da, wd, be, r, w, st, rwd);
        tests++; if (n !== TO || BusErr !== 1'b0 || WBData !== 32'hDEAD_BEEF || RegWriteOut !== 1'b1) begin
            fails++; $display("FAIL ack_at_limit: cycles=%0d BusErr=%b WBData=%h RegWriteOut=%b, required %0d 0 deadbeef 1", n, BusErr, WBData, RegWriteOut, TO); end
    endtask

    task automatic test_back_to_back();
        int n; logic [31:0] da, wd; logic [3:0] be; logic r, w, st, rwd;
        logic [31:0] hold; logic [4:0] hra; logic [31:0] rdata;
        for (int i = 0; i < 4; i++) begin
            hold = $urandom; hra = 5'($urandom); rdata = $urandom;
            mem_txn(1'b1, 1'b0, 2'b10, 32'h0000_0800, 32'h0, rdata, 1'b0, 1'b1, 1'b1, 5'd9,
                    i + 1, hold, hra, n, da, wd, be, r, w, st, rwd);
            tests++; if (WBData !== rdata || RAddrOut !== 5'd9 || RegWriteOut !== 1'b1) begin
                fails++; $display("FAIL b2b_load[%0d]: WBData=%h RAddrOut=%0d, required %h 9", i, WBData, RAddrOut, rdata); end
            @(negedge Clock);
            tests++; if (WBData !== hold || RAddrOut !== hra || RegWriteOut !== 1'b1 || Stall !== 1'b0) begin
                fails++; $display("FAIL b2b_held[%0d]: WBData=%h RAddrOut=%0d RegWriteOut=%b Stall=%b, required %h %0d 1 0", i, WBData, RAddrOut, RegWriteOut, Stall, hold, hra); end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge Clock);
        MemReadIn = 1'b1; MemWriteIn = 1'b0; Size = 2'b10; ALUOutIn = 32'h0000_0C00;
        RegWriteIn = 1'b1; RAddrIn = 5'd6; MemtoRegIn = 1'b1; DAck = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        set_nop(32'h1111_2222, 5'd1, 1'b0);
        @(negedge Clock);
        tests++; if (Stall !== 1'b1 || DRead !== 1'b1) begin
            fails++; $display("FAIL midreset_pre: Stall=%b DRead=%b, required 1 1", Stall, DRead); end
        nReset = 1'b0;
        #1;
        tests++; if (Stall !== 1'b0 || DRead !== 1'b0 || RegWriteOut !== 1'b0) begin
            fails++; $display("FAIL midreset_drop: Stall=%b DRead=%b RegWriteOut=%b, required 0 0 0", Stall, DRead, RegWriteOut); end
        set_nop(32'hCAFE_F00D, 5'd9, 1'b1);
        #1 nReset = 1'b1;
        @(posedge Clock);
        #1;
        tests++; if (WBData !== 32'hCAFE_F00D || RAddrOut !== 5'd9 || RegWriteOut !== 1'b1 || Stall !== 1'b0 || DRead !== 1'b0) begin
            fails++; $display("FAIL midreset_after: WBData=%h RAddrOut=%0d RegWriteOut=%b Stall=%b DRead=%b, required cafef00d 9 1 0 0", WBData, RAddrOut, RegWriteOut, Stall, DRead); end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load_directed();
        test_random_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
